// File: rtl/bit_serializer.sv
// bit_serializer: paced MSB-first parallel-to-serial stage with o_ce bit strobe.
// Optional even-parity trailer bit enabled by defining SERIALIZER_PARITY_EN.
module bit_serializer #(
    parameter int DW           = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int LGCLK        = 8
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_stb,
    input  logic [DW-1:0] i_word,
    output logic          o_busy,
    output logic          o_ce,
    output logic          o_bit
);
`ifdef SERIALIZER_PARITY_EN
    localparam int NB = DW + 1;
`else
    localparam int NB = DW;
`endif
    localparam int NBW = $clog2(NB + 1);
    localparam logic [LGCLK-1:0] PACE_MAX = LGCLK'(CLKS_PER_BIT - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state_q, state_d;
    logic [NB-1:0]     sreg_q, sreg_d, ld_sreg, cur_sreg;
    logic [NBW-1:0]    nbits_q, nbits_d, cur_nbits;
    logic [LGCLK-1:0]  pace_q, pace_d, cur_pace;
    logic              ce_q, ce_d, bit_q, bit_d;
    logic              accept, chain, step, fire, last;

`ifdef SERIALIZER_PARITY_EN
    assign ld_sreg = {i_word, ^i_word};
`else
    assign ld_sreg = i_word;
`endif

    // A word accepted right after the final strobe joins the running pace,
    // so it is loaded and stepped in the same cycle to keep spacing exact.
    assign accept    = i_stb && (state_q == IDLE);
    assign chain     = accept && ce_q;
    assign step      = (state_q == SHIFT) || chain;
    assign cur_sreg  = accept ? ld_sreg : sreg_q;
    assign cur_nbits = accept ? NBW'(NB) : nbits_q;
    assign cur_pace  = accept ? PACE_MAX : pace_q;
    assign fire      = step && (cur_pace == '0);
    assign last      = fire && (cur_nbits == NBW'(1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            nbits_q <= '0;
            pace_q  <= '0;
            ce_q    <= 1'b0;
            bit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            nbits_q <= nbits_d;
            pace_q  <= pace_d;
            ce_q    <= ce_d;
            bit_q   <= bit_d;
        end
    end

    always_comb begin
        state_d = last ? IDLE : (accept || state_q == SHIFT) ? SHIFT : IDLE;
    end

    always_comb begin
        sreg_d  = fire ? cur_sreg << 1 : cur_sreg;
        nbits_d = fire ? cur_nbits - NBW'(1) : cur_nbits;
        pace_d  = !step ? cur_pace : fire ? PACE_MAX : cur_pace - LGCLK'(1);
        ce_d    = fire;
        bit_d   = fire ? cur_sreg[NB-1] : bit_q;
    end

    assign o_busy = (state_q == SHIFT);
    assign o_ce   = ce_q;
    assign o_bit  = bit_q;
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: directed checks of strobe timing and bit order, CLKS_PER_BIT=4 and 1.
module tb_bit_serializer;
    localparam int C = 4;
`ifdef SERIALIZER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk = 1'b0, rst = 1'b1, stb0 = 1'b0, stb1 = 1'b0;
    logic [7:0] w0 = '0, w1 = '0;
    logic       busy0, ce0, bit0, busy1, ce1, bit1;
    int         cyc = 0, nchk = 0, npass = 0, t0;
    bit         q0b[$], q1b[$];
    int         q0t[$], q1t[$];

    bit_serializer #(.DW(8), .CLKS_PER_BIT(C), .LGCLK(8)) u0 (
        .i_clk(clk), .i_reset(rst), .i_stb(stb0), .i_word(w0),
        .o_busy(busy0), .o_ce(ce0), .o_bit(bit0)
    );
    bit_serializer #(.DW(8), .CLKS_PER_BIT(1), .LGCLK(8)) u1 (
        .i_clk(clk), .i_reset(rst), .i_stb(stb1), .i_word(w1),
        .o_busy(busy1), .o_ce(ce1), .o_bit(bit1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (ce0) begin q0b.push_back(bit0); q0t.push_back(cyc); end
        if (ce1) begin q1b.push_back(bit1); q1t.push_back(cyc); end
    end

    task automatic chk(input string tag, input int got, input int exp);
        nchk++;
        if (got == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int exp_bit(input logic [7:0] w, input int k);
        return (k < 8) ? int'(w[7-k]) : int'(^w);
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic accept(input int sel, input logic [7:0] w, input bit hold, output int t);
        @(negedge clk);
        if (sel == 0) begin stb0 = 1'b1; w0 = w; end
        else begin stb1 = 1'b1; w1 = w; end
        @(negedge clk);
        t = cyc;
        if (!hold) begin stb0 = 1'b0; stb1 = 1'b0; end
    endtask

    task automatic stream(input string tag, input int sel, input logic [7:0] w,
                          input int idx0, input int t, input int c);
        for (int k = 0; k < NB; k++) begin
            int idx, sz;
            idx = idx0 + k;
            sz  = (sel == 0) ? q0b.size() : q1b.size();
            if (idx < sz) begin
                chk({tag, "_time"}, (sel == 0) ? q0t[idx] : q1t[idx], t + c * (idx + 1));
                chk({tag, "_bit"}, (sel == 0) ? int'(q0b[idx]) : int'(q1b[idx]), exp_bit(w, k));
            end else chk({tag, "_missing"}, sz, idx + 1);
        end
    endtask

    initial begin
        idle(3);
        chk("rst_busy", busy0, 0);
        chk("rst_ce", ce0, 0);
        chk("rst_bit", bit0, 0);
        rst = 1'b0;
        idle(2);

        q0b.delete(); q0t.delete();
        accept(0, 8'hA5, 1'b0, t0);
        chk("t1_busy_on", busy0, 1);
        for (int i = 0; i < NB * C + 8; i++) begin
            @(negedge clk);
            if (cyc == t0 + NB * C - 1) chk("t1_busy_hi", busy0, 1);
            if (cyc == t0 + NB * C) chk("t1_busy_lo", busy0, 0);
        end
        chk("t1_count", q0b.size(), NB);
        stream("t1", 0, 8'hA5, 0, t0, C);
        chk("t1_hold", bit0, exp_bit(8'hA5, NB - 1));
        chk("t1_idle_ce", ce0, 0);

        q0b.delete(); q0t.delete();
        accept(0, 8'hA5, 1'b1, t0);
        w0 = 8'h3C;
        for (int i = 0; i < 2 * NB * C + 10; i++) begin
            @(negedge clk);
            if (cyc == t0 + NB * C + 1) stb0 = 1'b0;
        end
        chk("t2_count", q0b.size(), 2 * NB);
        stream("t2a", 0, 8'hA5, 0, t0, C);
        stream("t2b", 0, 8'h3C, NB, t0, C);

        q0b.delete(); q0t.delete();
        accept(0, 8'hA5, 1'b0, t0);
        stb0 = 1'b1;
        w0 = 8'hFF;
        for (int i = 0; i < NB * C + 10; i++) begin
            @(negedge clk);
            if (cyc == t0 + NB * C - 1) stb0 = 1'b0;
        end
        chk("t3_count", q0b.size(), NB);
        stream("t3", 0, 8'hA5, 0, t0, C);
        chk("t3_busy", busy0, 0);

        q0b.delete(); q0t.delete();
        accept(0, 8'hA5, 1'b0, t0);
        for (int i = 0; i < 40 && q0b.size() < 3; i++) @(negedge clk);
        chk("t4_pre", q0b.size(), 3);
        rst = 1'b1;
        @(negedge clk);
        chk("t4_ce", ce0, 0);
        chk("t4_bit", bit0, 0);
        chk("t4_busy", busy0, 0);
        rst = 1'b0;
        idle(40);
        chk("t4_nomore", q0b.size(), 3);
        q0b.delete(); q0t.delete();
        accept(0, 8'h81, 1'b0, t0);
        idle(NB * C + 5);
        chk("t4_count", q0b.size(), NB);
        stream("t4", 0, 8'h81, 0, t0, C);

        q1b.delete(); q1t.delete();
        accept(1, 8'hC3, 1'b0, t0);
        idle(NB + 5);
        chk("t5_count", q1b.size(), NB);
        stream("t5", 1, 8'hC3, 0, t0, 1);
        chk("t5_busy", busy1, 0);

        q0b.delete(); q0t.delete();
        accept(0, 8'h07, 1'b0, t0);
        idle(NB * C + 5);
        chk("t6_count", q0b.size(), NB);
        stream("t6", 0, 8'h07, 0, t0, C);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
